// File: rtl/ib_compact_queue_pkg.sv
// Shared constants and the renPkt bundle for the decode/rename instruction buffer.
// Optional INST_BUF_PERF_EN adds stall/empty cycle counters on the top.
package ib_compact_queue_pkg;
  localparam int FETCH_WIDTH    = 4;
  localparam int DISPATCH_WIDTH = 4;
  localparam int IB_DEPTH       = 32;
  localparam int IB_SLOTS       = 2 * FETCH_WIDTH;
  localparam int IB_PTR_W       = $clog2(IB_DEPTH);
  localparam int IB_CNT_W       = $clog2(IB_DEPTH + 1);
  localparam int IB_OFF_W       = $clog2(IB_SLOTS);
  localparam int IB_NWR_W       = $clog2(IB_SLOTS + 1);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } renPkt;
endpackage

// File: rtl/ib_compact.sv
// Prefix sum over slot valids: per-slot write offset and total written count.
module ib_compact
  import ib_compact_queue_pkg::*;
(
  input  logic [IB_SLOTS-1:0]               valid,
  output logic [IB_SLOTS-1:0][IB_OFF_W-1:0] offset,
  output logic [IB_NWR_W-1:0]               n_wr
);
  always_comb begin
    n_wr   = '0;
    offset = '0;
    for (int k = 0; k < IB_SLOTS; k++) begin
      offset[k] = n_wr[IB_OFF_W-1:0];
      n_wr      = n_wr + IB_NWR_W'(valid[k]);
    end
  end
endmodule

// File: rtl/ib_compact_queue.sv
// Compacting circular instruction buffer between decode and rename.
// Define INST_BUF_PERF_EN to add stallCycles_o / emptyCycles_o counters.
module ib_compact_queue
  import ib_compact_queue_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic                           decodeReady_i,
  input  renPkt [IB_SLOTS-1:0]           ibPacket_i,
  input  logic                           renameReady_i,
  output renPkt [DISPATCH_WIDTH-1:0]     renPacket_o,
  output logic                           instBufferReady_o,
  output logic                           stallFetch_o,
`ifdef INST_BUF_PERF_EN
  output logic [31:0]                    stallCycles_o,
  output logic [31:0]                    emptyCycles_o,
`endif
  output logic [IB_CNT_W-1:0]            ibCount_o
);
  logic [IB_PTR_W-1:0]               head_ptr;
  logic [IB_PTR_W-1:0]               tail_ptr;
  logic [IB_CNT_W-1:0]               count;
  renPkt                             mem [IB_DEPTH];
  logic [IB_SLOTS-1:0]               slot_valid;
  logic [IB_SLOTS-1:0][IB_OFF_W-1:0] offset;
  logic [IB_NWR_W-1:0]               n_wr;
  logic                              wr;
  logic                              rd;
  logic [IB_CNT_W-1:0]               n_add;

  always_comb begin
    for (int k = 0; k < IB_SLOTS; k++)
      slot_valid[k] = ibPacket_i[k].valid;
  end

  ib_compact u_compact (
    .valid  (slot_valid),
    .offset (offset),
    .n_wr   (n_wr)
  );

  assign wr    = decodeReady_i & ~stallFetch_o & ~flush_i & ~reset;
  assign rd    = instBufferReady_o & renameReady_i & ~flush_i & ~reset;
  assign n_add = wr ? IB_CNT_W'(n_wr) : '0;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      assert (count <= IB_CNT_W'(IB_DEPTH));
      tail_ptr <= tail_ptr + IB_PTR_W'(n_add);
      if (rd)
        head_ptr <= head_ptr + IB_PTR_W'(DISPATCH_WIDTH);
      count <= count + n_add
             - (rd ? IB_CNT_W'(DISPATCH_WIDTH) : '0);
    end
  end

  // Storage needs no reset: occupancy masks anything stale.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IB_SLOTS; k++) begin
      if (wr && slot_valid[k])
        mem[tail_ptr + IB_PTR_W'(offset[k])] <= ibPacket_i[k];
    end
  end

  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      renPacket_o[i]       = mem[head_ptr + IB_PTR_W'(i)];
      renPacket_o[i].valid = mem[head_ptr + IB_PTR_W'(i)].valid
                           && (IB_CNT_W'(i) < count);
    end
  end

  assign instBufferReady_o = count >= IB_CNT_W'(DISPATCH_WIDTH);
  assign stallFetch_o      = (IB_CNT_W'(IB_DEPTH) - count)
                           < IB_CNT_W'(IB_SLOTS);
  assign ibCount_o         = count;

`ifdef INST_BUF_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycles_o <= '0;
      emptyCycles_o <= '0;
    end else begin
      if (decodeReady_i && stallFetch_o && stallCycles_o != '1)
        stallCycles_o <= stallCycles_o + 32'd1;
      if (count == '0 && emptyCycles_o != '1)
        emptyCycles_o <= emptyCycles_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ib_compact_queue.sv
// Directed bench for ib_compact_queue: compaction, stall, wrap, flush.
module tb_ib_compact_queue;
  import ib_compact_queue_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       flush_i;
  logic                       decodeReady_i;
  renPkt [IB_SLOTS-1:0]       ibPacket_i;
  logic                       renameReady_i;
  renPkt [DISPATCH_WIDTH-1:0] renPacket_o;
  logic                       instBufferReady_o;
  logic                       stallFetch_o;
  logic [IB_CNT_W-1:0]        ibCount_o;
`ifdef INST_BUF_PERF_EN
  logic [31:0]                stallCycles_o;
  logic [31:0]                emptyCycles_o;
`endif

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ib_compact_queue dut (
    .clk               (clk),
    .reset             (reset),
    .flush_i           (flush_i),
    .decodeReady_i     (decodeReady_i),
    .ibPacket_i        (ibPacket_i),
    .renameReady_i     (renameReady_i),
    .renPacket_o       (renPacket_o),
    .instBufferReady_o (instBufferReady_o),
    .stallFetch_o      (stallFetch_o),
`ifdef INST_BUF_PERF_EN
    .stallCycles_o     (stallCycles_o),
    .emptyCycles_o     (emptyCycles_o),
`endif
    .ibCount_o         (ibCount_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bundle(input logic [7:0] mask, input logic [31:0] base);
    for (int k = 0; k < IB_SLOTS; k++) begin
      ibPacket_i[k].valid = mask[k];
      ibPacket_i[k].pc    = base + 32'(k);
      ibPacket_i[k].inst  = ~(base + 32'(k));
    end
  endtask

  task automatic chk_state(input string tag, input int cnt,
                           input logic rdy, input logic stl);
    chk({tag, ".count"}, 32'(ibCount_o), 32'(cnt));
    chk({tag, ".ready"}, 32'(instBufferReady_o), 32'(rdy));
    chk({tag, ".stall"}, 32'(stallFetch_o), 32'(stl));
  endtask

  task automatic chk_out(input string tag, input logic [3:0] vmask,
                         input logic [31:0] p0, input logic [31:0] p1,
                         input logic [31:0] p2, input logic [31:0] p3);
    logic [3:0]  v;
    logic [31:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      v[i] = renPacket_o[i].valid;
    chk({tag, ".vld"}, 32'(v), 32'(vmask));
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (vmask[i]) begin
        chk($sformatf("%s.pc%0d", tag, i), renPacket_o[i].pc, p[i]);
        chk($sformatf("%s.in%0d", tag, i), renPacket_o[i].inst, ~p[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; decodeReady_i = 1'b0;
    renameReady_i = 1'b0;
    bundle(8'h00, 32'h0);
    step(); step();
    reset = 1'b0;
    chk_state("reset", 0, 1'b0, 1'b0);
    chk_out("reset", 4'b0000, 0, 0, 0, 0);

    // full bundle, then drain in two reads
    bundle(8'hFF, 32'h100); decodeReady_i = 1'b1;
    step();
    decodeReady_i = 1'b0;
    chk_state("full8", 8, 1'b1, 1'b0);
    chk_out("full8", 4'b1111, 32'h100, 32'h101, 32'h102, 32'h103);
    renameReady_i = 1'b1;
    step();
    chk_state("rd1", 4, 1'b1, 1'b0);
    chk_out("rd1", 4'b1111, 32'h104, 32'h105, 32'h106, 32'h107);
    step();
    renameReady_i = 1'b0;
    chk_state("rd2", 0, 1'b0, 1'b0);

    // sparse bundle: slots 0,2,5,6 compacted
    bundle(8'h65, 32'h200); decodeReady_i = 1'b1;
    step();
    decodeReady_i = 1'b0;
    chk_state("sparse", 4, 1'b1, 1'b0);
    chk_out("sparse", 4'b1111, 32'h200, 32'h202, 32'h205, 32'h206);
    renameReady_i = 1'b1;
    step();
    renameReady_i = 1'b0;
    chk_state("sparse_rd", 0, 1'b0, 1'b0);

    // count=3: no partial read
    bundle(8'h07, 32'h300); decodeReady_i = 1'b1;
    step();
    decodeReady_i = 1'b0;
    chk_state("cnt3", 3, 1'b0, 1'b0);
    renameReady_i = 1'b1;
    step();
    renameReady_i = 1'b0;
    chk_state("cnt3_rd", 3, 1'b0, 1'b0);
    chk_out("cnt3_rd", 4'b0111, 32'h300, 32'h301, 32'h302, 32'h0);

    // grow to 12, then flush with write and read
    bundle(8'hFF, 32'h400); decodeReady_i = 1'b1;
    step();
    bundle(8'h01, 32'h500);
    step();
    chk_state("cnt12", 12, 1'b1, 1'b0);
    bundle(8'hFF, 32'h600); flush_i = 1'b1; renameReady_i = 1'b1;
    step();
    flush_i = 1'b0; decodeReady_i = 1'b0; renameReady_i = 1'b0;
    chk_state("flush", 0, 1'b0, 1'b0);
    chk_out("flush", 4'b0000, 0, 0, 0, 0);
    step();
    chk_state("flush_idle", 0, 1'b0, 1'b0);
    bundle(8'h0F, 32'h700); decodeReady_i = 1'b1;
    step();
    decodeReady_i = 1'b0;
    chk_state("post_flush", 4, 1'b1, 1'b0);
    chk_out("post_flush", 4'b1111, 32'h700, 32'h701, 32'h702, 32'h703);
    renameReady_i = 1'b1;
    step();
    renameReady_i = 1'b0;

    // head=tail=4; fill 24 -> tail=28
    decodeReady_i = 1'b1;
    bundle(8'hFF, 32'h800); step();
    bundle(8'hFF, 32'h810); step();
    bundle(8'hFF, 32'h820); step();
    decodeReady_i = 1'b0;
    chk_state("fill24", 24, 1'b1, 1'b0);
    chk_out("fill24", 4'b1111, 32'h800, 32'h801, 32'h802, 32'h803);

    // write 8 across index 31->0 while reading 4
    bundle(8'hFF, 32'h830); decodeReady_i = 1'b1; renameReady_i = 1'b1;
    step();
    decodeReady_i = 1'b0;
    chk_state("wrap", 28, 1'b1, 1'b1);
    chk_out("wrap", 4'b1111, 32'h804, 32'h805, 32'h806, 32'h807);
    step();
    renameReady_i = 1'b0;
    chk_state("rd24", 24, 1'b1, 1'b0);

    // count 25 -> stalled; offered bundle dropped
    bundle(8'h01, 32'h840); decodeReady_i = 1'b1;
    step();
    chk_state("cnt25", 25, 1'b1, 1'b1);
    bundle(8'hFF, 32'h850);
    step();
    decodeReady_i = 1'b0;
    chk_state("stalled", 25, 1'b1, 1'b1);
    chk_out("stalled", 4'b1111, 32'h810, 32'h811, 32'h812, 32'h813);

    // drain, checking order across the wrap
    renameReady_i = 1'b1;
    step();
    chk_out("dr1", 4'b1111, 32'h814, 32'h815, 32'h816, 32'h817);
    step();
    chk_out("dr2", 4'b1111, 32'h820, 32'h821, 32'h822, 32'h823);
    step();
    chk_out("dr3", 4'b1111, 32'h824, 32'h825, 32'h826, 32'h827);
    step();
    chk_state("dr4", 9, 1'b1, 1'b0);
    chk_out("dr4", 4'b1111, 32'h830, 32'h831, 32'h832, 32'h833);
    step();
    chk_out("dr5", 4'b1111, 32'h834, 32'h835, 32'h836, 32'h837);
    step();
    renameReady_i = 1'b0;
    chk_state("dr6", 1, 1'b0, 1'b0);
    chk_out("dr6", 4'b0001, 32'h840, 32'h0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
